// File: rtl/calc_pkg.sv
// Shared calculator definitions: dtype codes, ASCII constants, operator codes
// and the result encoder state encoding.
package calc_pkg;

    localparam logic [3:0] DTYPE_S = 4'd1;
    localparam logic [3:0] DTYPE_U = 4'd2;

    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ASCII_MINUS      = 8'h2D;
    localparam logic [7:0] ASCII_EQ         = 8'h3D;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_E          = 8'h45;
    localparam logic [7:0] ASCII_R          = 8'h52;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6
    } calc_op_e;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_SIGN  = 3'd1;
    localparam logic [2:0] ENC_DIGIT = 3'd2;
    localparam logic [2:0] ENC_ERR   = 3'd3;
    localparam logic [2:0] ENC_CR    = 3'd4;
    localparam logic [2:0] ENC_LF    = 3'd5;
    localparam logic [2:0] ENC_DONE  = 3'd6;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex character.
module nibble_to_ascii
    import calc_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Select digit or letter range
    always_comb begin
        ascii = 8'h00;
        if (nibble >= 4'd10) begin
            ascii = ASCII_ALPHA_BASE + {4'd0, nibble - 4'd10};
        end else begin
            ascii = ASCII_DIGIT_BASE + {4'd0, nibble};
        end
    end

endmodule

// File: rtl/result_encoder.sv
// Serialises one captured ALU result as [-]HHHHHHHH CR LF (or ERR CR LF)
// over a valid/ready byte stream with registered outputs.
module result_encoder
    import calc_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [4*DIGITS-1:0]   result,
    input  logic [3:0]            dtype,
    input  logic                  error,
    input  logic                  calc_done,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  enc_busy,
    output logic                  enc_done
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             enc_busy_q, enc_busy_d;
    logic             enc_done_q, enc_done_d;

    logic             xfer_s;
    logic             neg_s;
    logic [W-1:0]     mag_s;
    logic [7:0]       digit_ascii_s;

    assign xfer_s = tx_valid_q && tx_ready;

    // Sign and two's-complement magnitude of the incoming result
    always_comb begin
        neg_s = (dtype == DTYPE_S) && result[W-1];
        mag_s = result;
        if (neg_s) begin
            mag_s = ~result + W'(1);
        end else begin
            mag_s = result;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ENC_IDLE: begin
                if (calc_done) begin
                    shift_d   = mag_s;
                    cnt_d     = CNT_W'(DIGITS - 1);
                    err_cnt_d = 2'd0;
                    if (error) begin
                        state_d = ENC_ERR;
                    end else if (neg_s) begin
                        state_d = ENC_SIGN;
                    end else begin
                        state_d = ENC_DIGIT;
                    end
                end else begin
                    state_d = ENC_IDLE;
                end
            end
            ENC_SIGN: begin
                if (xfer_s) begin
                    state_d = ENC_DIGIT;
                end else begin
                    state_d = ENC_SIGN;
                end
            end
            ENC_DIGIT: begin
                if (xfer_s) begin
                    shift_d = shift_q << 4;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ENC_CR;
                    end else begin
                        state_d = ENC_DIGIT;
                    end
                end else begin
                    state_d = ENC_DIGIT;
                end
            end
            ENC_ERR: begin
                if (xfer_s) begin
                    err_cnt_d = err_cnt_q + 2'd1;
                    if (err_cnt_q == 2'd2) begin
                        state_d = ENC_CR;
                    end else begin
                        state_d = ENC_ERR;
                    end
                end else begin
                    state_d = ENC_ERR;
                end
            end
            ENC_CR: begin
                if (xfer_s) begin
                    state_d = ENC_LF;
                end else begin
                    state_d = ENC_CR;
                end
            end
            ENC_LF: begin
                if (xfer_s) begin
                    state_d = ENC_DONE;
                end else begin
                    state_d = ENC_LF;
                end
            end
            ENC_DONE: begin
                state_d = ENC_IDLE;
            end
            default: begin
                state_d = ENC_IDLE;
            end
        endcase
    end

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (shift_d[W-1 -: 4]),
        .ascii  (digit_ascii_s)
    );

    // Outputs are derived from the next state so they register alongside it
    always_comb begin
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        enc_busy_d = 1'b0;
        enc_done_d = 1'b0;
        case (state_d)
            ENC_SIGN: begin
                tx_data_d  = ASCII_MINUS;
                tx_valid_d = 1'b1;
                enc_busy_d = 1'b1;
            end
            ENC_DIGIT: begin
                tx_data_d  = digit_ascii_s;
                tx_valid_d = 1'b1;
                enc_busy_d = 1'b1;
            end
            ENC_ERR: begin
                tx_data_d  = (err_cnt_d == 2'd0) ? ASCII_E : ASCII_R;
                tx_valid_d = 1'b1;
                enc_busy_d = 1'b1;
            end
            ENC_CR: begin
                tx_data_d  = ASCII_CR;
                tx_valid_d = 1'b1;
                enc_busy_d = 1'b1;
            end
            ENC_LF: begin
                tx_data_d  = ASCII_LF;
                tx_valid_d = 1'b1;
                enc_busy_d = 1'b1;
            end
            ENC_DONE: begin
                enc_done_d = 1'b1;
            end
            default: begin
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= ENC_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            err_cnt_q  <= 2'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            enc_busy_q <= 1'b0;
            enc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            enc_busy_q <= enc_busy_d;
            enc_done_q <= enc_done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign enc_busy = enc_busy_q;
    assign enc_done = enc_done_q;

endmodule
